// File: rtl/mux_3x1_if.sv
// Signal bundle for the 3:1 operand selector: data inputs, select/clear controls and outputs.
// Carries parity_q only when MUX3X1_PARITY_EN is defined.
interface mux_3x1_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [1:0]       sel;
    logic             err_clr;
    logic [WIDTH-1:0] muxout;
    logic [WIDTH-1:0] muxout_q;
    logic             sel_err;
`ifdef MUX3X1_PARITY_EN
    logic             parity_q;

    modport master (
        output in1, in2, in3, sel, err_clr,
        input  muxout, muxout_q, sel_err, parity_q
    );
    modport slave (
        input  in1, in2, in3, sel, err_clr,
        output muxout, muxout_q, sel_err, parity_q
    );
`else
    modport master (
        output in1, in2, in3, sel, err_clr,
        input  muxout, muxout_q, sel_err
    );
    modport slave (
        input  in1, in2, in3, sel, err_clr,
        output muxout, muxout_q, sel_err
    );
`endif
endinterface

// File: rtl/mux_3x1.sv
// 3-input WIDTH-bit selector with combinational and registered outputs plus sticky illegal-select flag.
// Optional registered even-parity output enabled by defining MUX3X1_PARITY_EN.
module mux_3x1 #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    mux_3x1_if.slave bus
);
    logic [WIDTH-1:0] sel_data;
    logic             sel_illegal;
    logic [WIDTH-1:0] muxout_q_d;
    logic [WIDTH-1:0] muxout_q_q;
    logic             sel_err_d;
    logic             sel_err_q;

    // Unknown select propagates X so broken control shows up in simulation.
    always_comb begin
        sel_data = '0;
        case (bus.sel)
            2'd0:    sel_data = bus.in1;
            2'd1:    sel_data = bus.in2;
            2'd2:    sel_data = bus.in3;
            2'd3:    sel_data = '0;
            default: sel_data = 'x;
        endcase
    end

    assign sel_illegal = (bus.sel == 2'd3);

    // An illegal select freezes the data register; setting the flag beats clearing it.
    always_comb begin
        muxout_q_d = muxout_q_q;
        sel_err_d  = sel_err_q;
        if (sel_illegal) begin
            sel_err_d = 1'b1;
        end else begin
            muxout_q_d = sel_data;
            if (bus.err_clr) begin
                sel_err_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            muxout_q_q <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            muxout_q_q <= muxout_q_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign bus.muxout   = sel_data;
    assign bus.muxout_q = muxout_q_q;
    assign bus.sel_err  = sel_err_q;

`ifdef MUX3X1_PARITY_EN
    logic parity_q_d;
    logic parity_q_q;

    always_comb begin
        parity_q_d = parity_q_q;
        if (!sel_illegal) begin
            parity_q_d = ^sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q_q <= 1'b0;
        end else begin
            parity_q_q <= parity_q_d;
        end
    end

    assign bus.parity_q = parity_q_q;
`endif

endmodule

// File: tb/tb_mux_3x1.sv
// Scoreboard bench for mux_3x1: directed plan items followed by random traffic against a queue-fed model.
module tb_mux_3x1;
    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             err;
        logic             par;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   txn;
    exp_t sb[$];

    logic [WIDTH-1:0] model_q;
    logic             model_err;

    mux_3x1_if #(.WIDTH(WIDTH)) bus ();

    mux_3x1 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: act=%h req=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        int ones;
        ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) ones++;
        end
        return (ones % 2) == 1;
    endfunction

    // Called at a falling edge; returns at the next falling edge after the load.
    task automatic step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] c, input logic [1:0] s, input logic clr);
        logic [WIDTH-1:0] operands [4];
        exp_t e;
        bus.in1     = a;
        bus.in2     = b;
        bus.in3     = c;
        bus.sel     = s;
        bus.err_clr = clr;
        operands[0] = a;
        operands[1] = b;
        operands[2] = c;
        operands[3] = '0;
        #1;
        chk("muxout", {24'd0, bus.muxout}, {24'd0, operands[s]});
        if (s != 2'd3) model_q = operands[s];
        if (s == 2'd3) model_err = 1'b1;
        else if (clr) model_err = 1'b0;
        e.q   = model_q;
        e.err = model_err;
        e.par = even_parity(model_q);
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every edge that has an outstanding expectation is checked one unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                txn++;
                chk("muxout_q", {24'd0, bus.muxout_q}, {24'd0, e.q});
                chk("sel_err", {31'd0, bus.sel_err}, {31'd0, e.err});
`ifdef MUX3X1_PARITY_EN
                chk("parity_q", {31'd0, bus.parity_q}, {31'd0, e.par});
`endif
                $display("txn %0d: sel=%0d clr=%b muxout_q=%h sel_err=%b exp_q=%h exp_err=%b",
                         txn, bus.sel, bus.err_clr, bus.muxout_q, bus.sel_err, e.q, e.err);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        txn   = 0;
        model_q   = '0;
        model_err = 1'b0;
        rst_n       = 1'b1;
        bus.in1     = 8'd5;
        bus.in2     = 8'd0;
        bus.in3     = 8'd0;
        bus.sel     = 2'd0;
        bus.err_clr = 1'b0;
        #2 rst_n = 1'b0;

        // Reset held with clocks running
        repeat (2) @(posedge clk);
        #1;
        chk("rst_muxout", {24'd0, bus.muxout}, 32'd5);
        chk("rst_muxout_q", {24'd0, bus.muxout_q}, 32'd0);
        chk("rst_sel_err", {31'd0, bus.sel_err}, 32'd0);
`ifdef MUX3X1_PARITY_EN
        chk("rst_parity_q", {31'd0, bus.parity_q}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step(8'd5, 8'd0, 8'd0, 2'd0, 1'b0);

        // Select sweep
        step(8'd0, 8'd1, 8'd0, 2'd0, 1'b0);
        step(8'd1, 8'd1, 8'd0, 2'd0, 1'b0);
        step(8'd2, 8'd1, 8'd0, 2'd2, 1'b0);
        step(8'd0, 8'd1, 8'd0, 2'd1, 1'b0);
        step(8'd0, 8'd3, 8'd6, 2'd2, 1'b0);

        // Illegal select holds data and sets the sticky flag
        step(8'hFF, 8'hFF, 8'hFF, 2'd3, 1'b0);
        step(8'h11, 8'h22, 8'h33, 2'd0, 1'b0);

        // Error clear, then set-beats-clear
        step(8'h44, 8'h55, 8'h66, 2'd0, 1'b1);
        step(8'h44, 8'h55, 8'h66, 2'd3, 1'b0);
        step(8'h44, 8'h55, 8'h66, 2'd3, 1'b1);
        step(8'h44, 8'h55, 8'h66, 2'd1, 1'b1);

        // Parity pattern
        step(8'h00, 8'h07, 8'h00, 2'd1, 1'b0);
        step(8'h00, 8'h03, 8'h00, 2'd1, 1'b0);

        // Async reset between edges with state loaded
        step(8'h00, 8'h00, 8'h00, 2'd3, 1'b0);
        step(8'hA5, 8'h00, 8'h00, 2'd0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_muxout_q", {24'd0, bus.muxout_q}, 32'd0);
        chk("async_sel_err", {31'd0, bus.sel_err}, 32'd0);
`ifdef MUX3X1_PARITY_EN
        chk("async_parity_q", {31'd0, bus.parity_q}, 32'd0);
`endif
        @(posedge clk);
        #1;
        chk("hold_rst_muxout_q", {24'd0, bus.muxout_q}, 32'd0);
        chk("hold_rst_sel_err", {31'd0, bus.sel_err}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        model_q   = '0;
        model_err = 1'b0;
        step(8'h3C, 8'h00, 8'h00, 2'd0, 1'b0);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            step(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
